// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, controller FSM states, word type and
// the load value returned on a failed memory access.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'd0,
    MC_ACCESS = 2'd1,
    MC_RESP   = 2'd2,
    MC_ABORT  = 2'd3
  } memctrl_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam word_t ERRWORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter bounding how long one RAM access may take; expired is raised
// in the cycle where the count equals TIMEOUT-1.
module mem_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count_r;

  assign expired = (count_r == W'(TIMEOUT - 1));

  // Count access cycles; saturate at the expiry value
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (enable && !expired) begin
      count_r <= count_r + W'(1'b1);
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Cache-side memory controller: arbitrates instruction and data requests onto
// one RAM port, one transaction at a time, with error, timeout and abort paths.
module memory_controller
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT = 64,
  parameter word_t ERRWORD = cpu_types_pkg::ERRWORD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        merr
);

  memctrl_state_t state_r, state_s;
  owner_t         owner_r, owner_s;
  logic           wr_r, wr_s;
  logic           last_d_r;
  logic           grant_s, done_s, err_s;
  logic           d_req_s, owner_ren_s, expired_s;
  word_t          resp_word_s;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (state_r != MC_ACCESS),
    .enable  (state_r == MC_ACCESS),
    .expired (expired_s)
  );

  assign d_req_s     = dREN | dWEN;
  assign owner_ren_s = (owner_r == OWN_D) ? dREN : iREN;
  assign resp_word_s = err_s ? ERRWORD : ramload;

  // Next-state, arbitration and completion decode
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    wr_s    = wr_r;
    grant_s = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      MC_IDLE: begin
        // On contention the side that did not own the last grant goes first
        if (d_req_s && (!iREN || !last_d_r)) begin
          grant_s = 1'b1;
          owner_s = OWN_D;
          wr_s    = dWEN;
          state_s = MC_ACCESS;
        end else if (iREN) begin
          grant_s = 1'b1;
          owner_s = OWN_I;
          wr_s    = 1'b0;
          state_s = MC_ACCESS;
        end else begin
          state_s = MC_IDLE;
        end
      end
      MC_ACCESS: begin
        if (ramstate == ACCESS) begin
          done_s  = 1'b1;
          state_s = MC_RESP;
        end else if ((ramstate == ERROR) || expired_s) begin
          done_s  = 1'b1;
          err_s   = 1'b1;
          state_s = MC_RESP;
        end else if (!wr_r && !owner_ren_s) begin
          state_s = MC_ABORT;
        end else begin
          state_s = MC_ACCESS;
        end
      end
      MC_RESP:  state_s = MC_IDLE;
      MC_ABORT: state_s = MC_IDLE;
      default:  state_s = MC_IDLE;
    endcase
  end

  // State, request latches, RAM drive and per-side response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= MC_IDLE;
      owner_r  <= OWN_I;
      wr_r     <= 1'b0;
      last_d_r <= 1'b0;
      iwait    <= 1'b1;
      dwait    <= 1'b1;
      iload    <= 32'h0000_0000;
      dload    <= 32'h0000_0000;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= 32'h0000_0000;
      ramstore <= 32'h0000_0000;
      merr     <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      wr_r    <= wr_s;
      ramREN  <= (state_s == MC_ACCESS) && !wr_s;
      ramWEN  <= (state_s == MC_ACCESS) && wr_s;
      iwait   <= !((state_s == MC_RESP) && (owner_s == OWN_I));
      dwait   <= !((state_s == MC_RESP) && (owner_s == OWN_D));
      if (grant_s) begin
        last_d_r <= (owner_s == OWN_D);
        ramaddr  <= (owner_s == OWN_D) ? daddr : iaddr;
        ramstore <= (owner_s == OWN_D) ? dstore : 32'h0000_0000;
      end
      if (done_s && (owner_r == OWN_I)) begin
        iload <= resp_word_s;
      end
      if (done_s && (owner_r == OWN_D)) begin
        dload <= resp_word_s;
      end
      if (err_s) begin
        merr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Randomized bench for memory_controller: cache-like requesters and a RAM model
// feed a scoreboard that a separate monitor drains on every wait-low pulse.
module tb_memory_controller;
  import cpu_types_pkg::*;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  logic        merr;

  memory_controller #(.TIMEOUT(TO), .ERRWORD(ERRWORD)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit    side_d;
    word_t data;
    bit    err;
    int    due;
  } exp_t;

  exp_t  sb[$];
  word_t mem[word_t];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  bit    i_done = 1'b0;
  bit    d_done = 1'b0;
  bit    merr_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_iwait"},    32'(iwait),  32'd1);
    check({tag, "_dwait"},    32'(dwait),  32'd1);
    check({tag, "_iload"},    iload,       32'd0);
    check({tag, "_dload"},    dload,       32'd0);
    check({tag, "_ramREN"},   32'(ramREN), 32'd0);
    check({tag, "_ramWEN"},   32'(ramWEN), 32'd0);
    check({tag, "_ramaddr"},  ramaddr,     32'd0);
    check({tag, "_ramstore"}, ramstore,    32'd0);
    check({tag, "_merr"},     32'(merr),   32'd0);
  endtask

  function automatic word_t memval(input word_t a);
    memval = mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B1) ^ 32'h1357_2468);
  endfunction

  // Monitor: every wait-low pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && (!iwait || !dwait)) begin
        check("wait_exclusive", 32'(iwait | dwait), 32'd1);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: wait low at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = sb.pop_front();
          check("resp_side", 32'(!dwait), 32'(e.side_d));
          check("resp_cycle", 32'(cyc), 32'(e.due));
          check("resp_data", e.side_d ? dload : iload, e.data);
          if (e.err) merr_model = 1'b1;
          check("merr_sticky", 32'(merr), 32'(merr_model));
        end
        if (!iwait) i_done = 1'b1;
        if (!dwait) d_done = 1'b1;
      end
    end
  end

  // Stimulus: two requesters plus a RAM model with random latency/error/stall
  initial begin
    bit    in_acc, expect_low, own_d_m, last_d_m, pd, stop;
    bit    ia, da, dw;
    int    acnt, lat, mode, r, iage, dage;
    word_t resp_val, acc_addr;
    exp_t  ne;

    in_acc = 1'b0; expect_low = 1'b0; own_d_m = 1'b0; last_d_m = 1'b0; stop = 1'b0;
    ia = 1'b0; da = 1'b0; dw = 1'b0; acnt = 0; lat = 0; mode = 0; iage = 0; dage = 0;
    resp_val = 32'd0; acc_addr = 32'd0;

    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
    ramstate = FREE; ramload = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset("reset");
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int k = 0; k < 3400 && !stop; k++) begin
      @(posedge CLK); #1;
      cyc++;
      ramstate = FREE;
      ramload  = $urandom;

      // RAM model: new grant prediction, then drive this cycle's response
      if (expect_low) begin
        check("enables_low", 32'(ramREN | ramWEN), 32'd0);
        expect_low = 1'b0;
      end else if (!in_acc && (ramREN || ramWEN)) begin
        pd = dREN | dWEN;
        if (!pd && !iREN) begin
          tests++;
          fails++;
          $display("FAIL spurious_grant: RAM enabled at cycle %0d with no request", cyc);
        end
        own_d_m  = (pd && iREN) ? !last_d_m : pd;
        last_d_m = own_d_m;
        acc_addr = own_d_m ? daddr : iaddr;
        check("grant_addr", ramaddr, acc_addr);
        check("grant_wen", 32'(ramWEN), own_d_m ? 32'(dWEN) : 32'd0);
        check("grant_ren", 32'(ramREN), own_d_m ? 32'(!dWEN) : 32'd1);
        r    = $urandom_range(0, 11);
        mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
        lat  = $urandom_range(0, 3);
        if (own_d_m && dWEN) begin
          check("grant_store", ramstore, dstore);
          resp_val = (mode == 1) ? $urandom : dstore;
          if (mode == 0) mem[daddr] = dstore;
        end else begin
          resp_val = (mode == 1) ? $urandom : memval(acc_addr);
        end
        ne.side_d = own_d_m;
        ne.err    = (mode != 0);
        ne.data   = (mode == 0) ? resp_val : ERRWORD;
        ne.due    = cyc + ((mode == 2) ? TO : lat + 1);
        sb.push_back(ne);
        in_acc = 1'b1;
        acnt   = 0;
      end
      if (in_acc) begin
        if (!(ramREN || ramWEN)) begin
          tests++;
          fails++;
          $display("FAIL enables_dropped: RAM enables low mid-access at cycle %0d", cyc);
          in_acc = 1'b0;
        end else begin
          ramstate = BUSY;
          if ((mode != 2 && acnt == lat) || (mode == 2 && acnt == TO - 1)) begin
            if (mode != 2) begin
              ramstate = (mode == 1) ? ERROR : ACCESS;
              ramload  = resp_val;
            end
            check("latched_addr", ramaddr, acc_addr);
            in_acc     = 1'b0;
            expect_low = 1'b1;
          end
          acnt++;
        end
      end

      // Instruction requester
      if (i_done) begin
        iREN = 1'b0; ia = 1'b0; i_done = 1'b0; iage = 0;
      end else if (ia) begin
        iage++;
        if (in_acc && !own_d_m && $urandom_range(0, 15) == 0) begin
          iREN = 1'b0; ia = 1'b0; iage = 0;
          in_acc = 1'b0; expect_low = 1'b1;
          sb.delete(sb.size() - 1);
        end else if (in_acc && !own_d_m) begin
          iaddr = $urandom;
        end
      end else begin
        iaddr = $urandom;
        if (k < 3000 && $urandom_range(0, 1) == 1) begin
          ia = 1'b1; iREN = 1'b1;
          iaddr = 32'($urandom_range(0, 63)) << 2;
        end
      end

      // Data requester
      if (d_done) begin
        dREN = 1'b0; dWEN = 1'b0; da = 1'b0; d_done = 1'b0; dage = 0;
      end else if (da) begin
        dage++;
        if (in_acc && own_d_m && !dw && $urandom_range(0, 15) == 0) begin
          dREN = 1'b0; da = 1'b0; dage = 0;
          in_acc = 1'b0; expect_low = 1'b1;
          sb.delete(sb.size() - 1);
        end else if (in_acc && own_d_m) begin
          daddr  = $urandom;
          dstore = $urandom;
        end
      end else begin
        daddr  = $urandom;
        dstore = $urandom;
        if (k < 3000 && $urandom_range(0, 1) == 1) begin
          da = 1'b1;
          dw = ($urandom_range(0, 2) == 0);
          dWEN = dw; dREN = !dw;
          daddr = 32'($urandom_range(0, 63)) << 2;
        end
      end

      if (iage > 60 || dage > 60) begin
        tests++;
        fails++;
        $display("FAIL request_starved: iage %0d dage %0d at cycle %0d", iage, dage, cyc);
        stop = 1'b1;
      end
      if (k >= 3000 && !ia && !da && !in_acc && !expect_low && sb.size() == 0) stop = 1'b1;
    end
    check("drain_outstanding", 32'(sb.size()) + 32'(ia) + 32'(da), 32'd0);

    // Reset in the middle of a write abandons it and restores reset values
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    repeat (3) @(posedge CLK);
    #1;
    dWEN = 1'b1; daddr = 32'h0000_0300; dstore = 32'hCAFE_F00D; ramstate = BUSY;
    @(posedge CLK); #1;
    check("midrst_wen", 32'(ramWEN), 32'd1);
    check("midrst_addr", ramaddr, 32'h0000_0300);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    dWEN = 1'b0; ramstate = FREE; merr_model = 1'b0;
    check_reset("midrst");
    RST = 1'b0;
    repeat (4) @(posedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
